// File: rtl/value_bias_pkg.sv
// value_bias_pkg: shared sizing helpers, default widths and types for the
// value bias-add stage (value_bias_add and value_bias_skid_buffer).
package value_bias_pkg;

  localparam int unsigned VB_DIN_W   = 16;
  localparam int unsigned VB_DIN_F   = 3;
  localparam int unsigned VB_BIAS_W  = 16;
  localparam int unsigned VB_BIAS_F  = 3;
  localparam int unsigned VB_OUT_W   = 16;
  localparam int unsigned VB_TENSOR  = 32;
  localparam int unsigned VB_PAR     = 1;

  // Left shift that brings the bias onto the data_in binary point
  localparam int unsigned VB_SHIFT = VB_DIN_F - VB_BIAS_F;

  function automatic int unsigned align_shift(input int unsigned din_f,
                                              input int unsigned bias_f);
    return (din_f >= bias_f) ? (din_f - bias_f) : 0;
  endfunction

  // Lossless sum width: widest aligned operand plus one carry bit
  function automatic int unsigned sum_width(input int unsigned din_w,
                                            input int unsigned bias_w,
                                            input int unsigned shift);
    int unsigned aligned_w;
    aligned_w = bias_w + shift;
    return ((din_w > aligned_w) ? din_w : aligned_w) + 1;
  endfunction

  typedef struct packed {
    logic [VB_PAR-1:0][VB_OUT_W-1:0] lanes;
    logic                            last;
  } vb_entry_t;

  localparam int unsigned VB_ENTRY_W = $bits(vb_entry_t);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/value_bias_skid_buffer.sv
// value_bias_skid_buffer: two-entry registered valid/ready buffer; space_c lets
// the producer refill in the same cycle that the head drains.
module value_bias_skid_buffer
  import value_bias_pkg::*;
#(
  parameter int unsigned W = VB_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         space_c,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         valid_q, valid_d;
  logic         run_q;
  logic         pop_c;

  assign pop_c     = valid_q & out_ready;
  // run_q keeps both input readies low until the first edge after reset release
  assign space_c   = run_q & ((state_q != SKID_FULL) | pop_c);
  assign out_data  = head_q;
  assign out_valid = valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      run_q   <= 1'b1;
    end
  end

  // Occupancy transitions; head always holds the oldest beat
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          head_d  = push_data;
          valid_d = 1'b1;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (push && pop_c) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = SKID_FULL;
        end else if (pop_c) begin
          valid_d = 1'b0;
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop_c) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            state_d = SKID_ONE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = SKID_EMPTY;
      end
    endcase
  end

endmodule

// File: rtl/value_bias_add.sv
// value_bias_add: joins matmul lanes with bias lanes, adds with binary-point
// alignment and emits a buffered stream tagged with end-of-row. Define
// VALUE_BIAS_ADD_SAT_EN for per-lane saturation and the sticky sat_flag port.
module value_bias_add
  import value_bias_pkg::*;
#(
  parameter int unsigned DATA_IN_PRECISION_0  = VB_DIN_W,
  parameter int unsigned DATA_IN_PRECISION_1  = VB_DIN_F,
  parameter int unsigned BIAS_PRECISION_0     = VB_BIAS_W,
  parameter int unsigned BIAS_PRECISION_1     = VB_BIAS_F,
  parameter int unsigned DATA_OUT_PRECISION_0 = VB_OUT_W,
  parameter int unsigned TENSOR_SIZE_DIM_0    = VB_TENSOR,
  parameter int unsigned PARALLELISM_DIM_0    = VB_PAR,
  parameter int unsigned BLOCKS_PER_ROW       = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [PARALLELISM_DIM_0*DATA_IN_PRECISION_0-1:0]    data_in,
  input  logic                                                data_in_valid,
  output logic                                                data_in_ready,
  input  logic [PARALLELISM_DIM_0*BIAS_PRECISION_0-1:0]       bias_in,
  input  logic                                                bias_in_valid,
  output logic                                                bias_in_ready,
  output logic [PARALLELISM_DIM_0*DATA_OUT_PRECISION_0-1:0]   data_out,
  output logic                                                data_out_valid,
  input  logic                                                data_out_ready,
  output logic                                                data_out_last
`ifdef VALUE_BIAS_ADD_SAT_EN
 ,output logic                                                sat_flag
`endif
);

  localparam int unsigned PAR     = PARALLELISM_DIM_0;
  localparam int unsigned DIN_W   = DATA_IN_PRECISION_0;
  localparam int unsigned BIAS_W  = BIAS_PRECISION_0;
  localparam int unsigned OUT_W   = DATA_OUT_PRECISION_0;
  localparam int unsigned SHIFT   = align_shift(DATA_IN_PRECISION_1, BIAS_PRECISION_1);
  localparam int unsigned SUM_W   = sum_width(DIN_W, BIAS_W, SHIFT);
  // One extra bit over both the sum and the output keeps the range test exact
  localparam int unsigned CMP_W   = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
  localparam int unsigned COL_W   = (BLOCKS_PER_ROW > 1) ? $clog2(BLOCKS_PER_ROW) : 1;
  localparam int unsigned LANES_W = PAR * OUT_W;
  localparam int unsigned ENTRY_W = LANES_W + 1;

  if (BIAS_PRECISION_1 > DATA_IN_PRECISION_1) begin : g_bad_frac
    $error("value_bias_add: BIAS_PRECISION_1 must not exceed DATA_IN_PRECISION_1");
  end
  if ((TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0) != 0) begin : g_bad_par
    $error("value_bias_add: PARALLELISM_DIM_0 must divide TENSOR_SIZE_DIM_0");
  end

  logic               space_c;
  logic               fire_c;
  logic               last_c;
  logic [COL_W-1:0]   col_q;
  logic [LANES_W-1:0] lanes_c;
  logic [ENTRY_W-1:0] out_entry;
`ifdef VALUE_BIAS_ADD_SAT_EN
  logic [PAR-1:0]     lane_sat_c;
  logic               sat_q;
`endif

  // Join: both streams pop together so bias stays aligned with its column
  assign fire_c        = data_in_valid & bias_in_valid & space_c;
  assign data_in_ready = bias_in_valid & space_c;
  assign bias_in_ready = data_in_valid & space_c;

  for (genvar l = 0; l < PAR; l++) begin : g_lane
    logic signed [DIN_W-1:0]  din_c;
    logic signed [BIAS_W-1:0] bias_c;
    logic signed [CMP_W-1:0]  sum_c;

    assign din_c  = data_in[l*DIN_W +: DIN_W];
    assign bias_c = bias_in[l*BIAS_W +: BIAS_W];
    assign sum_c  = CMP_W'(din_c) + (CMP_W'(bias_c) <<< SHIFT);

`ifdef VALUE_BIAS_ADD_SAT_EN
    // Out of range whenever the bits above the output sign are not a sign copy
    logic ovf_c;
    assign ovf_c = (|sum_c[CMP_W-1:OUT_W-1]) & ~(&sum_c[CMP_W-1:OUT_W-1]);
    assign lane_sat_c[l] = ovf_c;
    assign lanes_c[l*OUT_W +: OUT_W] =
      !ovf_c         ? sum_c[OUT_W-1:0] :
      sum_c[CMP_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                       {1'b0, {(OUT_W-1){1'b1}}};
`else
    logic unused_hi_c;
    assign unused_hi_c = ^sum_c[CMP_W-1:OUT_W];
    assign lanes_c[l*OUT_W +: OUT_W] = sum_c[OUT_W-1:0];
`endif
  end

  assign last_c = (col_q == COL_W'(BLOCKS_PER_ROW - 1));

  // Column of the next accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
    end else if (fire_c) begin
      col_q <= last_c ? '0 : col_q + COL_W'(1);
    end
  end

`ifdef VALUE_BIAS_ADD_SAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else if (fire_c && (|lane_sat_c)) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`endif

  value_bias_skid_buffer #(
    .W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (fire_c),
    .push_data ({lanes_c, last_c}),
    .space_c   (space_c),
    .out_data  (out_entry),
    .out_valid (data_out_valid),
    .out_ready (data_out_ready)
  );

  assign data_out      = out_entry[ENTRY_W-1:1];
  assign data_out_last = out_entry[0];

endmodule

// File: doc/value_bias_add.md
Name: value_bias_add

Overview:
- Streaming bias-add stage directly downstream of the value-bias source.
- Joins the value-projection matmul output stream with the bias stream lane-by-lane and adds them with fixed-point alignment.
- Emits a registered, backpressure-safe output stream with an end-of-row marker to the attention-score datapath.

Parameters:
- DATA_IN_PRECISION_0, 16, data_in total bits (signed).
- DATA_IN_PRECISION_1, 3, data_in fractional bits.
- BIAS_PRECISION_0, 16, bias total bits (signed).
- BIAS_PRECISION_1, 3, bias fractional bits; must be <= DATA_IN_PRECISION_1 (elaboration error otherwise).
- DATA_OUT_PRECISION_0, 16, output total bits; output fractional bits = DATA_IN_PRECISION_1.
- TENSOR_SIZE_DIM_0, 32, row length in elements.
- PARALLELISM_DIM_0, 1, lanes per beat; must divide TENSOR_SIZE_DIM_0.
- BLOCKS_PER_ROW, TENSOR_SIZE_DIM_0/PARALLELISM_DIM_0, beats per row (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- data_in  in  [PARALLELISM_DIM_0] x DATA_IN_PRECISION_0  matmul result lanes
- data_in_valid  in  1  data beat valid
- data_in_ready  out  1  data beat accepted
- bias_in  in  [PARALLELISM_DIM_0] x BIAS_PRECISION_0  bias lanes from the bias source
- bias_in_valid  in  1  bias beat valid
- bias_in_ready  out  1  bias beat accepted
- data_out  out  [PARALLELISM_DIM_0] x DATA_OUT_PRECISION_0  biased result
- data_out_valid  out  1  output valid
- data_out_ready  in  1  downstream ready
- data_out_last  out  1  beat is the final block of a row

Behaviour:
- Join: fire = data_in_valid & bias_in_valid & space. data_in_ready = bias_in_valid & space. bias_in_ready = data_in_valid & space. Both streams pop on the same cycle or neither does; bias never advances alone, which keeps the bias column in lock-step with the data column.
- space = skid buffer holds fewer than 2 entries after accounting for same-cycle drain.
- Arithmetic per lane:
  - bias is sign-extended and left-shifted by (DATA_IN_PRECISION_1 - BIAS_PRECISION_1).
  - data_in is sign-extended.
  - Sum width = max(aligned widths) + 1, lossless.
  - Output = low DATA_OUT_PRECISION_0 bits of the sum (two's-complement wrap) unless the saturation feature is enabled.
- Column counter: 0..BLOCKS_PER_ROW-1. Increments on fire and wraps to 0 after BLOCKS_PER_ROW-1. data_out_last is tagged on the beat whose column equals BLOCKS_PER_ROW-1 and travels with that beat through the buffer.
- Pipeline: sum registered into a 2-entry skid buffer (head/tail). Latency from fire to data_out_valid is 1 cycle when empty. Throughput is 1 beat/cycle with data_out_ready held high.
- Output stability: data_out, data_out_last and data_out_valid stay stable while valid=1 and ready=0.
- Full buffer: both ready outputs low. Simultaneous drain and fire on a full buffer is permitted (count stays 2).
- Reset (async assert, sync release):
  - data_out_valid=0, data_out=0, data_out_last=0.
  - Column counter=0, buffer empty.
  - data_in_ready=0, bias_in_ready=0.
- Reset mid-row discards buffered beats and restarts at column 0. The bias source must be reset concurrently.
- PARALLELISM_DIM_0 == TENSOR_SIZE_DIM_0 (BLOCKS_PER_ROW=1): data_out_last is asserted on every beat.

Optional Feature:
- VALUE_BIAS_ADD_SAT_EN defined: each lane clamps to [-2^(DATA_OUT_PRECISION_0-1), 2^(DATA_OUT_PRECISION_0-1)-1] instead of wrapping. The sticky output port sat_flag (1 bit) goes high on any clamp and is cleared only by reset.
- Undefined: wrap arithmetic; sat_flag port absent.

Decomposition:
- Shared package value_bias_pkg:
  - function for the aligned sum width.
  - localparam for the shift amount.
  - typedef for the buffer entry struct (lanes + last).
- One sub-module, value_bias_skid_buffer: 2-entry valid/ready buffer parameterised on the entry width.

Test Plan:
- Defaults, data_in lane=0x0010 (2.0), bias=0x0008 (1.0), all ready → data_out=0x0018 one cycle after fire; last asserted on the 32nd beat only.
- BIAS_PRECISION_1=1, DATA_IN_PRECISION_1=3, bias=0x0003 (1.5), data=0x0004 (0.5) → data_out=0x0010 (2.0).
- data_in_valid held low 5 cycles with bias_in_valid=1 → bias_in_ready=0 throughout, no bias consumed; column index resumes correctly.
- data_out_ready=0 for 4 cycles during streaming → exactly 2 beats buffered, both input readies low, no loss or duplication on release; output order matches input.
- data=0x7FFF, bias=0x0001: without SAT_EN → 0x8000. With VALUE_BIAS_ADD_SAT_EN → 0x7FFF and sat_flag=1.
- rst asserted at column 17 with 2 buffered beats → data_out_valid drops immediately (async); after release the first beat is column 0 and last appears 32 beats later.
